// File: rtl/mtimer.sv
// Machine timer: 64-bit mtime with prescaler, 64-bit compare, level interrupt, 32-bit register bus.
// One-cycle bus acknowledge; no request is accepted while mem_ready is high.
module mtimer #(
  parameter int unsigned PRESCALE_RESET = 0,
  parameter int unsigned PRESCALE_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_sel,
  input  logic [4:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        timer_irq
);

  localparam logic [2:0] R_MTIME_LO    = 3'd0;
  localparam logic [2:0] R_MTIME_HI    = 3'd1;
  localparam logic [2:0] R_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] R_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] R_CTRL        = 3'd4;
  localparam logic [2:0] R_PRESCALE    = 3'd5;

  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;
  logic                  en;
  logic                  ie;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pcnt;
  logic [31:0]           hi_shadow;

  logic        accept;
  logic        wr_en;
  logic        rd_en;
  logic        tick;
  logic [2:0]  idx;
  logic [31:0] rd_word;
  logic [31:0] wr_base;
  logic [31:0] wr_word;
  logic [31:0] prescale_ext;
  logic        addr_unused;

  logic wr_mtime_lo;
  logic wr_mtime_hi;
  logic wr_cmp_lo;
  logic wr_cmp_hi;
  logic wr_ctrl;
  logic wr_prescale;

  assign accept       = mem_valid & mem_sel & ~mem_ready;
  assign wr_en        = accept & (|mem_wstrb);
  assign rd_en        = accept & ~(|mem_wstrb);
  assign idx          = mem_addr[4:2];
  assign addr_unused  = ^mem_addr[1:0];
  assign prescale_ext = 32'(prescale);
  assign tick         = en & (pcnt == prescale);

  assign wr_mtime_lo  = wr_en & (idx == R_MTIME_LO);
  assign wr_mtime_hi  = wr_en & (idx == R_MTIME_HI);
  assign wr_cmp_lo    = wr_en & (idx == R_MTIMECMP_LO);
  assign wr_cmp_hi    = wr_en & (idx == R_MTIMECMP_HI);
  assign wr_ctrl      = wr_en & (idx == R_CTRL);
  assign wr_prescale  = wr_en & (idx == R_PRESCALE);

  // MTIME_HI reads the shadow captured by the last MTIME_LO read, but writes merge into the live word.
  always_comb begin
    rd_word = 32'd0;
    wr_base = 32'd0;
    case (idx)
      R_MTIME_LO: begin
        rd_word = mtime[31:0];
        wr_base = mtime[31:0];
      end
      R_MTIME_HI: begin
        rd_word = hi_shadow;
        wr_base = mtime[63:32];
      end
      R_MTIMECMP_LO: begin
        rd_word = mtimecmp[31:0];
        wr_base = mtimecmp[31:0];
      end
      R_MTIMECMP_HI: begin
        rd_word = mtimecmp[63:32];
        wr_base = mtimecmp[63:32];
      end
      R_CTRL: begin
        rd_word = {30'd0, ie, en};
        wr_base = {30'd0, ie, en};
      end
      R_PRESCALE: begin
        rd_word = prescale_ext;
        wr_base = prescale_ext;
      end
      default: begin
        rd_word = 32'd0;
        wr_base = 32'd0;
      end
    endcase
  end

  always_comb begin
    wr_word = wr_base;
    for (int i = 0; i < 4; i++) begin
      if (mem_wstrb[i]) begin
        wr_word[8*i +: 8] = mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
      hi_shadow <= 32'd0;
    end else begin
      mem_ready <= accept;
      mem_rdata <= rd_en ? rd_word : 32'd0;
      if (rd_en && (idx == R_MTIME_LO)) begin
        hi_shadow <= mtime[63:32];
      end
    end
  end

  // A bus write to either mtime half wins over a coincident tick; the increment is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime <= 64'd0;
    end else if (wr_mtime_lo) begin
      mtime[31:0] <= wr_word;
    end else if (wr_mtime_hi) begin
      mtime[63:32] <= wr_word;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
    end else if (wr_ctrl || wr_prescale || tick) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= pcnt + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtimecmp <= '1;
      en       <= 1'b1;
      ie       <= 1'b0;
      prescale <= PRESCALE_W'(PRESCALE_RESET);
    end else begin
      if (wr_cmp_lo) mtimecmp[31:0]  <= wr_word;
      if (wr_cmp_hi) mtimecmp[63:32] <= wr_word;
      if (wr_ctrl) begin
        en <= wr_word[0];
        ie <= wr_word[1];
      end
      if (wr_prescale) prescale <= wr_word[PRESCALE_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_irq <= 1'b0;
    end else begin
      timer_irq <= ie & (mtime >= mtimecmp);
    end
  end

endmodule
